// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit with pipelined ibus requests and a prefetch buffer
// Optional perf counters: define IFU_PREFETCH_PERF_EN.
module ifu_prefetch #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        stall_i,
    input  logic        jtag_halt_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic [31:0] ibus_addr_o,
    input  logic [31:0] ibus_data_i,
    output logic [31:0] ibus_data_o,
    output logic [3:0]  ibus_sel_o,
    output logic        ibus_we_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    output logic [31:0] perf_empty_cnt_o,
    output logic [31:0] perf_discard_cnt_o
);

    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          run;
    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic          buf_empty;
    logic [31:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;
    logic          rsp_drop;

    assign ibus_data_o = 32'h0;
    assign ibus_sel_o  = 4'hf;
    assign ibus_we_o   = 1'b0;
    assign rsp_ready_o = 1'b1;
    assign ibus_addr_o = fetch_pc;

    assign buf_empty   = (count == '0);
    // Buffer slots already promised to in-flight requests count against free space.
    assign credit_used = 32'(count) + 32'(outstanding);
    assign req_valid_o = run && !flush_i && !jtag_halt_i
                         && (32'(outstanding) < MAX_OUTSTANDING)
                         && (credit_used < FIFO_DEPTH);

    assign issue    = req_valid_o && req_ready_i;
    assign rsp_drop = rsp_valid_i && (flush_i || (discard_cnt != '0));
    assign push     = rsp_valid_i && !flush_i && (discard_cnt == '0);

    assign inst_valid_o = !buf_empty && !flush_i;
    assign pop          = inst_valid_o && !stall_i;
    assign inst_o       = buf_empty ? NOP    : buf_inst[rd_ptr];
    assign pc_o         = buf_empty ? rsp_pc : buf_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            run         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (flush_i) begin
                // Every request still in flight after this cycle must be dropped.
                fetch_pc    <= flush_addr_i;
                rsp_pc      <= flush_addr_i;
                outstanding <= outstanding - OW'(rsp_valid_i);
                discard_cnt <= outstanding - OW'(rsp_valid_i);
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (issue && !rsp_valid_i) begin
                    outstanding <= outstanding + OW'(1);
                end else if (!issue && rsp_valid_i) begin
                    outstanding <= outstanding - OW'(1);
                end
                if (rsp_valid_i && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - OW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= ibus_data_i;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef IFU_PREFETCH_PERF_EN
    logic [31:0] perf_empty_q;
    logic [31:0] perf_discard_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_empty_q   <= '0;
            perf_discard_q <= '0;
        end else begin
            if (buf_empty && !flush_i && (perf_empty_q != 32'hFFFF_FFFF)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
            if (rsp_drop && (perf_discard_q != 32'hFFFF_FFFF)) begin
                perf_discard_q <= perf_discard_q + 32'd1;
            end
        end
    end

    assign perf_empty_cnt_o   = perf_empty_q;
    assign perf_discard_cnt_o = perf_discard_q;
`else
    logic unused_perf;
    assign unused_perf        = rsp_drop;
    assign perf_empty_cnt_o   = 32'h0;
    assign perf_discard_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch with a simple ibus responder
module tb_ifu_prefetch;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        stall_i;
    logic        jtag_halt_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;
    logic [31:0] ibus_addr_o;
    logic [31:0] ibus_data_i;
    logic [31:0] ibus_data_o;
    logic [3:0]  ibus_sel_o;
    logic        ibus_we_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [31:0] perf_empty_cnt_o;
    logic [31:0] perf_discard_cnt_o;

    int tests = 0;
    int fails = 0;
    bit rsp_en;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];

    ifu_prefetch dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .stall_i(stall_i), .jtag_halt_i(jtag_halt_i), .inst_o(inst_o), .pc_o(pc_o),
        .inst_valid_o(inst_valid_o), .ibus_addr_o(ibus_addr_o), .ibus_data_i(ibus_data_i),
        .ibus_data_o(ibus_data_o), .ibus_sel_o(ibus_sel_o), .ibus_we_o(ibus_we_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .rsp_valid_i(rsp_valid_i),
        .rsp_ready_o(rsp_ready_o), .perf_empty_cnt_o(perf_empty_cnt_o),
        .perf_discard_cnt_o(perf_discard_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return 32'hC0DE_0000 + addr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory-like responder: answers accepted requests in order, one cycle later when enabled.
    initial begin
        bit          hs;
        logic [31:0] a;
        rsp_valid_i = 1'b0;
        ibus_data_i = 32'h0;
        forever begin
            @(negedge clk);
            hs = req_valid_o && req_ready_i;
            a  = ibus_addr_o;
            @(posedge clk);
            #2;
            if (rst_n && hs) pend_q.push_back(a);
            if (rst_n && rsp_en && pend_q.size() > 0) begin
                rsp_valid_i = 1'b1;
                ibus_data_i = mem_data(pend_q.pop_front());
            end else begin
                rsp_valid_i = 1'b0;
                ibus_data_i = 32'h0;
            end
        end
    end

    // Monitor: every consumed head entry is compared against the next expected pc.
    initial begin
        logic [31:0] epc;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid_o && !stall_i && exp_q.size() > 0) begin
                epc = exp_q.pop_front();
                check("head_pc", pc_o, epc);
                check("head_inst", inst_o, mem_data(epc));
            end
        end
    end

    task automatic do_reset();
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        flush_addr_i = 32'h0;
        stall_i      = 1'b0;
        jtag_halt_i  = 1'b0;
        req_ready_i  = 1'b1;
        rsp_en       = 1'b1;
        exp_q.delete();
        pend_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name, input bit need_ready);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_valid_o && (req_ready_i || !need_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0; flush_addr_i = 32'h0; stall_i = 1'b0; jtag_halt_i = 1'b0;
        req_ready_i = 1'b1; rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(req_valid_o), 32'd0);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0);
        check("rst_perf_empty", perf_empty_cnt_o, 32'h0);
        check("rst_perf_discard", perf_discard_cnt_o, 32'h0);
        check("const_sel", 32'(ibus_sel_o), 32'hf);
        check("const_we", 32'(ibus_we_o), 32'h0);
        check("const_wdata", ibus_data_o, 32'h0);
        check("const_rsp_ready", 32'(rsp_ready_o), 32'h1);

        // Back-to-back sequential fetch.
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        wait_req("seq_first_req", 1'b1);
        check("seq_addr0", ibus_addr_o, 32'h0);
        @(negedge clk);
        check("seq_valid1", 32'(req_valid_o), 32'd1);
        check("seq_addr1", ibus_addr_o, 32'h4);
        @(negedge clk);
        check("seq_valid2", 32'(req_valid_o), 32'd1);
        check("seq_addr2", ibus_addr_o, 32'h8);
        drain("seq_drain");

        // Stall fills the buffer until credit runs out, then drains in order.
        do_reset();
        stall_i = 1'b1;
        repeat (15) @(negedge clk);
        check("stall_req_valid", 32'(req_valid_o), 32'd0);
        check("stall_inst_valid", 32'(inst_valid_o), 32'd1);
        check("stall_head_pc", pc_o, 32'h0);
        check("stall_next_addr", ibus_addr_o, 32'h10);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        tick();
        stall_i = 1'b0;
        drain("stall_drain");

        // Flush with two requests outstanding: both late responses dropped.
        do_reset();
        rsp_en = 1'b0;
        repeat (6) @(negedge clk);
        check("maxout_req_valid", 32'(req_valid_o), 32'd0);
        check("maxout_addr", ibus_addr_o, 32'h8);
        tick();
        flush_i = 1'b1;
        flush_addr_i = 32'h100;
        @(negedge clk);
        check("flush_req_valid", 32'(req_valid_o), 32'd0);
        check("flush_inst_valid", 32'(inst_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        rsp_en = 1'b1;
        exp_q = '{32'h100, 32'h104, 32'h108};
        drain("flush2_drain");
`ifdef IFU_PREFETCH_PERF_EN
        check("perf_discard", perf_discard_cnt_o, 32'd2);
`else
        check("perf_discard", perf_discard_cnt_o, 32'd0);
`endif

        // Flush coinciding with the only outstanding response.
        do_reset();
        rsp_en = 1'b0;
        wait_req("flush1_first_req", 1'b1);
        tick();
        jtag_halt_i = 1'b1;
        @(negedge clk);
        check("flush1_halted", 32'(req_valid_o), 32'd0);
        tick();
        rsp_en = 1'b1;
        flush_i = 1'b1;
        flush_addr_i = 32'h200;
        jtag_halt_i = 1'b0;
        @(negedge clk);
        check("flush1_inst_valid", 32'(inst_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush1_req_valid", 32'(req_valid_o), 32'd1);
        check("flush1_addr", ibus_addr_o, 32'h200);
        exp_q = '{32'h200, 32'h204};
        drain("flush1_drain");

        // Halt with one outstanding request: response still delivered.
        do_reset();
        rsp_en = 1'b0;
        wait_req("halt_first_req", 1'b1);
        tick();
        jtag_halt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_no_req", 32'(req_valid_o), 32'd0);
        end
        exp_q = '{32'h0};
        tick();
        rsp_en = 1'b1;
        drain("halt_drain");
        check("halt_still_no_req", 32'(req_valid_o), 32'd0);
        check("halt_hold_addr", ibus_addr_o, 32'h4);
        tick();
        jtag_halt_i = 1'b0;
        @(negedge clk);
        check("unhalt_req_valid", 32'(req_valid_o), 32'd1);
        check("unhalt_addr", ibus_addr_o, 32'h4);
        exp_q = '{32'h4, 32'h8};
        drain("unhalt_drain");

        // Back-pressure on the request channel.
        do_reset();
        req_ready_i = 1'b0;
        wait_req("bp_valid", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_valid", 32'(req_valid_o), 32'd1);
            check("bp_addr", ibus_addr_o, 32'h0);
        end
        exp_q = '{32'h0, 32'h4, 32'h8};
        tick();
        req_ready_i = 1'b1;
        drain("bp_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
